// File: rtl/video_timing_meter.sv
// Receive-side raster meter: measures line/frame geometry and locks once stable.
// Optional lock-loss counter is built when VTM_ERRCNT_EN is defined; otherwise err_cnt is tied to 0.
module video_timing_meter #(
  parameter int W           = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_pix,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         hbl,
  input  logic         vbl,
  output logic [W-1:0] htotal,
  output logic [W-1:0] hactive,
  output logic [W-1:0] vtotal,
  output logic [W-1:0] vactive,
  output logic         locked,
  output logic         frame_stb,
  output logic [7:0]   err_cnt
);

  localparam logic [W-1:0] CMAX = {W{1'b1}};

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  state_t       state, state_nxt;
  logic [7:0]   match, match_nxt;
  logic         hs_q, vs_q, hs_rise, vs_rise;
  logic [W-1:0] hcnt, hacnt, line_q, hact_q, vcnt, vacnt, ref_len;
  logic         ref_vld, bad;
  logic [W-1:0] line_new, hact_new, vcnt_new, vacnt_new, cand_len, cand_hact;
  logic [W-1:0] prev_len, prev_hact, prev_v, prev_va;
  logic         frame_bad, timeout, cand_eq, load_res, stb_nxt;

  assign hs_rise   = clk_pix & hsync & ~hs_q;
  assign vs_rise   = clk_pix & vsync & ~vs_q;
  assign line_new  = sat_inc(hcnt);
  assign hact_new  = hbl ? hacnt : sat_inc(hacnt);
  assign vcnt_new  = hs_rise ? sat_inc(vcnt) : vcnt;
  assign vacnt_new = (hs_rise && !vbl) ? sat_inc(vacnt) : vacnt;
  // A coincident hsync rise closes its line into the frame that is closing now.
  assign cand_len  = hs_rise ? line_new : line_q;
  assign cand_hact = hs_rise ? hact_new : hact_q;
  assign frame_bad = bad
                   | (hs_rise & ((ref_vld & (line_new != ref_len))
                                 | (line_new == CMAX) | (hact_new == CMAX)))
                   | (vcnt_new == CMAX) | (vacnt_new == CMAX);
  assign timeout   = clk_pix & ((~hs_rise & (hcnt == CMAX)) | (~vs_rise & (vcnt == CMAX)));
  assign cand_eq   = ({cand_len, cand_hact, vcnt_new, vacnt_new}
                      == {prev_len, prev_hact, prev_v, prev_va});

  // Raster measurement counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hcnt    <= '0;
      hacnt   <= '0;
      line_q  <= '0;
      hact_q  <= '0;
      vcnt    <= '0;
      vacnt   <= '0;
      ref_len <= '0;
      ref_vld <= 1'b0;
      bad     <= 1'b0;
    end else if (clk_pix) begin
      hs_q <= hsync;
      vs_q <= vsync;
      if (hs_rise) begin
        hcnt   <= '0;
        hacnt  <= '0;
        line_q <= line_new;
        hact_q <= hact_new;
      end else begin
        hcnt  <= sat_inc(hcnt);
        hacnt <= hact_new;
      end
      if (vs_rise) begin
        vcnt    <= '0;
        vacnt   <= '0;
        bad     <= 1'b0;
        ref_vld <= 1'b0;
      end else begin
        vcnt  <= vcnt_new;
        vacnt <= vacnt_new;
        bad   <= frame_bad;
        if (hs_rise && !ref_vld) begin
          ref_len <= line_new;
          ref_vld <= 1'b1;
        end
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      match <= '0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_nxt = state;
    match_nxt = match;
    if (timeout) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end else if (vs_rise) begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          match_nxt = '0;
        end
        ACQUIRE: begin
          if (frame_bad)                  match_nxt = '0;
          else if (cand_eq || match == 0) match_nxt = match + 8'd1;
          else                            match_nxt = 8'd1;
          if (int'(match_nxt) >= LOCK_FRAMES) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (frame_bad || !cand_eq) begin
            state_nxt = ACQUIRE;
            match_nxt = frame_bad ? 8'd0 : 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end
  end

  // Lock FSM: outputs
  always_comb begin
    locked   = (state == LOCKED);
    load_res = (state != LOCKED) && (state_nxt == LOCKED);
    stb_nxt  = (state == LOCKED) && (state_nxt == LOCKED) && vs_rise;
  end

  // Results change only on entry into LOCKED
  always_ff @(posedge clk) begin
    if (reset) begin
      htotal    <= '0;
      hactive   <= '0;
      vtotal    <= '0;
      vactive   <= '0;
      frame_stb <= 1'b0;
      prev_len  <= '0;
      prev_hact <= '0;
      prev_v    <= '0;
      prev_va   <= '0;
    end else begin
      frame_stb <= stb_nxt;
      if (vs_rise) begin
        prev_len  <= cand_len;
        prev_hact <= cand_hact;
        prev_v    <= vcnt_new;
        prev_va   <= vacnt_new;
      end
      if (load_res) begin
        htotal  <= cand_len;
        hactive <= cand_hact;
        vtotal  <= vcnt_new;
        vactive <= vacnt_new;
      end
    end
  end

`ifdef VTM_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state == LOCKED) && (state_nxt != LOCKED);

  always_ff @(posedge clk) begin
    if (reset)                              err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_meter.sv
// Scoreboard bench for video_timing_meter: a small raster generator drives frames,
// expected lock/result state is queued at each vsync rise and compared one clk later.
module tb_video_timing_meter;
  localparam int W     = 10;
  localparam int LF    = 2;
  localparam int HT    = 32;
  localparam int HA_LO = 6;
  localparam int HA_HI = 29;
  localparam int HA    = HA_HI - HA_LO + 1;
  localparam int VT    = 16;
  localparam int VA_LO = 3;
  localparam int VA_HI = 14;
  localparam int VA    = VA_HI - VA_LO + 1;
`ifdef VTM_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, clk_pix, hsync, vsync, hbl, vbl;
  logic [W-1:0] htotal, hactive, vtotal, vactive;
  logic         locked, frame_stb;
  logic [7:0]   err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int pix_div     = 4;
  int close_n     = 0;

  typedef struct {
    bit lk;
    bit stb;
    int ht;
    int ha;
    int vt;
    int va;
    int ec;
  } exp_t;

  exp_t sbq[$];

  video_timing_meter #(.W(W), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .clk_pix(clk_pix),
    .hsync(hsync), .vsync(vsync), .hbl(hbl), .vbl(vbl),
    .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
    .locked(locked), .frame_stb(frame_stb), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int ec(input int n);
    return ERR_EN ? n : 0;
  endfunction

  function automatic exp_t mk(input bit lk, input bit stb, input int ht, input int ha,
                              input int vt, input int va, input int e);
    exp_t r;
    r.lk = lk; r.stb = stb; r.ht = ht; r.ha = ha; r.vt = vt; r.va = va; r.ec = e;
    return r;
  endfunction

  // One pixel enable followed by pix_div-1 disabled clocks carrying random garbage.
  task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb,
                     input bit chk);
    exp_t e;
    @(negedge clk);
    hsync = hs; vsync = vs; hbl = hb; vbl = vb; clk_pix = 1'b1;
    for (int i = 1; i < pix_div; i++) begin
      @(negedge clk);
      clk_pix = 1'b0;
      hsync = 1'($urandom); vsync = 1'($urandom);
      hbl   = 1'($urandom); vbl   = 1'($urandom);
      if (chk && i == 1) begin
        close_n++;
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL close%0d scoreboard empty", close_n);
        end else begin
          e = sbq.pop_front();
          if (locked !== e.lk || frame_stb !== e.stb || htotal !== W'(e.ht) ||
              hactive !== W'(e.ha) || vtotal !== W'(e.vt) || vactive !== W'(e.va) ||
              err_cnt !== 8'(e.ec)) begin
            miscompares++;
            $display("FAIL close%0d lk/stb/ht/ha/vt/va/ec got %0b/%0b/%0d/%0d/%0d/%0d/%0d want %0b/%0b/%0d/%0d/%0d/%0d/%0d",
                     close_n, locked, frame_stb, htotal, hactive, vtotal, vactive, err_cnt,
                     e.lk, e.stb, e.ht, e.ha, e.vt, e.va, e.ec);
          end
        end
      end
      if (chk && i == 2) begin
        vectors++;
        if (frame_stb !== 1'b0) begin
          miscompares++;
          $display("FAIL stb_width close%0d frame_stb got %0b want 0", close_n, frame_stb);
        end
      end
    end
  endtask

  // Frame opens with a coincident hsync+vsync rise, whose close result is queued as e.
  task automatic send_frame(input int nlines, input int short_line, input exp_t e);
    int len;
    sbq.push_back(e);
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++)
        pix(p < 4, l < 2, !(p >= HA_LO && p <= HA_HI), !(l >= VA_LO && l <= VA_HI),
            (l == 0 && p == 0));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; clk_pix = 1'b0;
    hsync = 1'b0; vsync = 1'b0; hbl = 1'b1; vbl = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (locked !== 1'b0)    begin miscompares++; $display("FAIL rst_locked got %0b want 0", locked); end
    if (frame_stb !== 1'b0) begin miscompares++; $display("FAIL rst_stb got %0b want 0", frame_stb); end
    if (htotal !== '0)      begin miscompares++; $display("FAIL rst_htotal got %0d want 0", htotal); end
    if (hactive !== '0)     begin miscompares++; $display("FAIL rst_hactive got %0d want 0", hactive); end
    if (vtotal !== '0)      begin miscompares++; $display("FAIL rst_vtotal got %0d want 0", vtotal); end
    if (vactive !== '0)     begin miscompares++; $display("FAIL rst_vactive got %0d want 0", vactive); end
    if (err_cnt !== 8'd0)   begin miscompares++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    reset = 1'b0;
  endtask

  // Lock after the third rise; vtotal counts the coincident closing line exactly.
  task automatic test_clean;
    pix_div = 4;
    send_frame(VT, -1, mk(0, 0, 0, 0, 0, 0, 0));
    send_frame(VT, -1, mk(0, 0, 0, 0, 0, 0, 0));
    send_frame(VT, -1, mk(1, 0, HT, HA, VT, VA, 0));
    send_frame(VT, -1, mk(1, 1, HT, HA, VT, VA, 0));
    send_frame(VT, -1, mk(1, 1, HT, HA, VT, VA, 0));
  endtask

  task automatic test_lock_loss;
    pix_div = 3;
    send_frame(VT + 1, -1, mk(1, 1, HT, HA, VT, VA, ec(0)));
    send_frame(VT, -1, mk(0, 0, HT, HA, VT, VA, ec(1)));
    send_frame(VT, -1, mk(0, 0, HT, HA, VT, VA, ec(1)));
    send_frame(VT, -1, mk(1, 0, HT, HA, VT, VA, ec(1)));
    send_frame(VT, -1, mk(1, 1, HT, HA, VT, VA, ec(1)));
  endtask

  task automatic test_bad_line;
    send_frame(VT, 8, mk(1, 1, HT, HA, VT, VA, ec(1)));
    send_frame(VT, -1, mk(0, 0, HT, HA, VT, VA, ec(2)));
    send_frame(VT, -1, mk(0, 0, HT, HA, VT, VA, ec(2)));
    send_frame(VT, -1, mk(1, 0, HT, HA, VT, VA, ec(2)));
    send_frame(VT, -1, mk(1, 1, HT, HA, VT, VA, ec(2)));
  endtask

  // Stall hsync past the counter range, then relock onto a 17-line raster.
  task automatic test_timeout;
    for (int n = 0; n < 1030; n++) pix(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors += 7;
    if (locked !== 1'b0)     begin miscompares++; $display("FAIL to_locked got %0b want 0", locked); end
    if (frame_stb !== 1'b0)  begin miscompares++; $display("FAIL to_stb got %0b want 0", frame_stb); end
    if (htotal !== W'(HT))   begin miscompares++; $display("FAIL to_htotal got %0d want %0d", htotal, HT); end
    if (hactive !== W'(HA))  begin miscompares++; $display("FAIL to_hactive got %0d want %0d", hactive, HA); end
    if (vtotal !== W'(VT))   begin miscompares++; $display("FAIL to_vtotal got %0d want %0d", vtotal, VT); end
    if (vactive !== W'(VA))  begin miscompares++; $display("FAIL to_vactive got %0d want %0d", vactive, VA); end
    if (err_cnt !== 8'(ec(3))) begin miscompares++; $display("FAIL to_err got %0d want %0d", err_cnt, ec(3)); end
    send_frame(VT + 1, -1, mk(0, 0, HT, HA, VT, VA, ec(3)));
    send_frame(VT + 1, -1, mk(0, 0, HT, HA, VT, VA, ec(3)));
    send_frame(VT + 1, -1, mk(1, 0, HT, HA, VT + 1, VA, ec(3)));
    send_frame(VT + 1, -1, mk(1, 1, HT, HA, VT + 1, VA, ec(3)));
  endtask

  task automatic test_mid_reset;
    send_frame(5, -1, mk(1, 1, HT, HA, VT + 1, VA, ec(3)));
    @(negedge clk);
    reset = 1'b1; clk_pix = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (locked !== 1'b0)    begin miscompares++; $display("FAIL mr_locked got %0b want 0", locked); end
    if (frame_stb !== 1'b0) begin miscompares++; $display("FAIL mr_stb got %0b want 0", frame_stb); end
    if (htotal !== '0)      begin miscompares++; $display("FAIL mr_htotal got %0d want 0", htotal); end
    if (hactive !== '0)     begin miscompares++; $display("FAIL mr_hactive got %0d want 0", hactive); end
    if (vtotal !== '0)      begin miscompares++; $display("FAIL mr_vtotal got %0d want 0", vtotal); end
    if (vactive !== '0)     begin miscompares++; $display("FAIL mr_vactive got %0d want 0", vactive); end
    if (err_cnt !== 8'd0)   begin miscompares++; $display("FAIL mr_err got %0d want 0", err_cnt); end
    reset = 1'b0;
    send_frame(VT, -1, mk(0, 0, 0, 0, 0, 0, 0));
    send_frame(VT, -1, mk(0, 0, 0, 0, 0, 0, 0));
    send_frame(VT, -1, mk(1, 0, HT, HA, VT, VA, 0));
    send_frame(2, -1, mk(1, 1, HT, HA, VT, VA, 0));
  endtask

  initial begin
    test_reset();
    test_clean();
    test_lock_loss();
    test_bad_line();
    test_timeout();
    test_mid_reset();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain pending got %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
